// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - captures a BCD result and scans it onto a multiplexed 7-segment display
// Capture on flag rising edge, prescaled digit scan, optional leading-zero blanking, sticky error.
module bcd_seg_scan #(
  parameter int SCAN_DIV = 4,
  parameter int DIV_W    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flag,
  input  logic [9:0] i_bcd_in,
  input  logic       i_blank_en,
  output logic [6:0] o_seg,
  output logic [2:0] o_dig_sel,
  output logic       o_frame_done,
  output logic       o_err
);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2} state_t;

  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(SCAN_DIV - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [DIV_W-1:0] r_cnt;
  logic [9:0]       r_held;
  logic             r_loaded;
  logic             r_flag_d;
  logic [6:0]       r_seg;
  logic [2:0]       r_dig_sel;
  logic             r_frame_done;
  logic             r_err;

  logic             w_cap;
  logic             w_valid;
  logic             w_tick;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [6:0]       w_seg;
  logic [2:0]       w_dig_sel;
  logic             w_frame_done;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  assign w_cap   = i_flag & ~r_flag_d;
  assign w_valid = (i_bcd_in[9:8] <= 2'd2) && (i_bcd_in[7:4] <= 4'd9) && (i_bcd_in[3:0] <= 4'd9);
  assign w_tick  = (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_flag_d <= 1'b0;
      r_held   <= 10'd0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_state  <= DIG0;
    end else begin
      r_flag_d <= i_flag;
      r_cnt    <= w_tick ? '0 : r_cnt + 1'b1;
      r_state  <= w_next_state;
      if (w_cap) begin
        if (w_valid) begin
          r_held   <= i_bcd_in;
          r_loaded <= 1'b1;
        end else begin
          r_err    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_tick) begin
      case (r_state)
        DIG0:    w_next_state = DIG1;
        DIG1:    w_next_state = DIG2;
        default: w_next_state = DIG0;
      endcase
    end
  end

  // Display path works from registered state/held, so every change shows one clock later.
  always_comb begin
    w_digit      = r_held[3:0];
    w_blank      = 1'b0;
    w_dig_sel    = 3'b001;
    w_frame_done = r_loaded & w_tick & (r_state == DIG2);
    case (r_state)
      DIG0: begin
        w_digit   = r_held[3:0];
        w_dig_sel = 3'b001;
      end
      DIG1: begin
        w_digit   = r_held[7:4];
        w_dig_sel = 3'b010;
        w_blank   = i_blank_en && (r_held[9:8] == 2'd0) && (r_held[7:4] == 4'd0);
      end
      default: begin
        w_digit   = {2'b00, r_held[9:8]};
        w_dig_sel = 3'b100;
        w_blank   = i_blank_en && (r_held[9:8] == 2'd0);
      end
    endcase
    w_seg = w_blank ? 7'h00 : seg_decode(w_digit);
    if (!r_loaded) begin
      w_seg     = 7'h00;
      w_dig_sel = 3'b000;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_seg        <= 7'h00;
      r_dig_sel    <= 3'b000;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg;
      r_dig_sel    <= w_dig_sel;
      r_frame_done <= w_frame_done;
    end
  end

  assign o_seg        = r_seg;
  assign o_dig_sel    = r_dig_sel;
  assign o_frame_done = r_frame_done;
  assign o_err        = r_err;

endmodule
